// File: rtl/fetch_unit.sv
// Instruction fetch: one memory read per FETCH visit of the control unit, with timeout and branch load.
// Latency: mem_req one edge after FETCH; ir/pc update on the edge after mem_ready; no flow-control backpressure.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  state_reg,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] ir,
  output logic [6:0]  opcode,
  output logic [31:0] pc,
  output logic        fetch_done,
  output logic        fetch_err
);

  typedef enum logic [1:0] {F_IDLE = 2'd0, F_WAIT = 2'd1, F_DONE = 2'd2} fstate_t;

  localparam logic [3:0] ST_FETCH = 4'b0001;
  localparam logic [3:0] ST_WB    = 4'b0100;
  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  fstate_t     state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic is_fetch, start, capture, timeout;

  assign is_fetch = (state_reg == ST_FETCH);
  assign start    = (state_q == F_IDLE) && is_fetch;
  assign capture  = (state_q == F_WAIT) && mem_ready;
  assign timeout  = (state_q == F_WAIT) && !mem_ready && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= F_IDLE;
    else        state_q <= state_d;
  end

  // F_DONE holds until the control unit leaves FETCH so each visit fetches once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      F_IDLE:  if (is_fetch) state_d = F_WAIT;
      F_WAIT:  if (capture || timeout) state_d = F_DONE;
      F_DONE:  if (!is_fetch) state_d = F_IDLE;
      default: state_d = F_IDLE;
    endcase
  end

  always_comb begin
    mem_req_d = mem_req_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    done_d    = capture;
    err_d     = err_q | timeout;
    if (start) begin
      mem_req_d = 1'b1;
      cnt_d     = 4'd0;
    end
    if (capture || timeout) mem_req_d = 1'b0;
    if ((state_q == F_WAIT) && !mem_ready && !timeout) cnt_d = cnt_q + 4'd1;
    // Capture increment wins over a coincident branch load.
    if (capture) begin
      ir_d = mem_rdata;
      pc_d = pc_q + 32'd4;
    end else if (pc_load && (state_reg == ST_WB)) begin
      pc_d = pc_target & 32'hFFFF_FFFC;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      cnt_q     <= 4'd0;
      mem_req_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      mem_req_q <= mem_req_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = pc_q;
  assign ir         = ir_q;
  assign opcode     = ir_q[6:0];
  assign pc         = pc_q;
  assign fetch_done = done_q;
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch, held FETCH, timeout, branch load, wrap and mid-wait reset.
module tb_fetch_unit;

  localparam logic [3:0] S_IDLE = 4'b0000, S_FETCH = 4'b0001, S_DECODE = 4'b0010,
                         S_EXEC = 4'b0011, S_WB = 4'b0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  state_reg;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] ir;
  logic [6:0]  opcode;
  logic [31:0] pc;
  logic        fetch_done;
  logic        fetch_err;

  int tests = 0;
  int fails = 0;
  int done_cnt;

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
    .clk(clk), .reset(rst_n), .state_reg(state_reg), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .pc_load(pc_load), .pc_target(pc_target),
    .mem_req(mem_req), .mem_addr(mem_addr), .ir(ir), .opcode(opcode), .pc(pc),
    .fetch_done(fetch_done), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; state_reg = S_IDLE; mem_ready = 1'b0; mem_rdata = 32'd0;
    pc_load = 1'b0; pc_target = 32'd0;
    tick; tick;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_done", {31'd0, fetch_done}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    rst_n = 1'b1;
    tick;

    // Basic fetch
    state_reg = S_FETCH;
    tick;
    chk("basic_req1", {31'd0, mem_req}, 32'd1);
    chk("basic_addr", mem_addr, 32'd0);
    tick;
    chk("basic_req2", {31'd0, mem_req}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    tick;
    chk("basic_ir", ir, 32'h0050_0093);
    chk("basic_opcode", {25'd0, opcode}, 32'h13);
    chk("basic_pc", pc, 32'd4);
    chk("basic_done", {31'd0, fetch_done}, 32'd1);
    chk("basic_req_off", {31'd0, mem_req}, 32'd0);
    mem_ready = 1'b0; state_reg = S_DECODE;
    tick;
    chk("basic_done_pulse", {31'd0, fetch_done}, 32'd0);

    // Held FETCH for 6 cycles with one ready pulse and a stray ready while idle-requested
    state_reg = S_FETCH; done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      mem_ready = (i == 1) || (i == 3);
      mem_rdata = (i == 3) ? 32'hBAD0_0001 : 32'h0000_0013;
      tick;
      if (fetch_done) done_cnt++;
    end
    mem_ready = 1'b0;
    chk("held_done_cnt", done_cnt, 32'd1);
    chk("held_pc", pc, 32'd8);
    chk("held_ir", ir, 32'h0000_0013);
    state_reg = S_IDLE;
    tick;

    // Ready on the 15th wait cycle wins over timeout; FETCH dropped mid-wait
    state_reg = S_FETCH;
    tick;
    state_reg = S_DECODE;
    for (int i = 0; i < 14; i++) tick;
    chk("late_req_held", {31'd0, mem_req}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick;
    mem_ready = 1'b0;
    chk("late_ir", ir, 32'hDEAD_BEEF);
    chk("late_opcode", {25'd0, opcode}, 32'h6F);
    chk("late_pc", pc, 32'd12);
    chk("late_err", {31'd0, fetch_err}, 32'd0);
    tick;

    // Timeout
    state_reg = S_FETCH;
    tick;
    state_reg = S_DECODE;
    for (int i = 0; i < 14; i++) tick;
    chk("to_err_pre", {31'd0, fetch_err}, 32'd0);
    chk("to_req_pre", {31'd0, mem_req}, 32'd1);
    tick;
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_req", {31'd0, mem_req}, 32'd0);
    chk("to_pc", pc, 32'd12);
    chk("to_ir", ir, 32'hDEAD_BEEF);
    chk("to_done", {31'd0, fetch_done}, 32'd0);
    tick;

    // Undefined control state is not FETCH
    state_reg = 4'hF;
    tick;
    chk("undef_state", {31'd0, mem_req}, 32'd0);

    // Branch load
    state_reg = S_WB; pc_load = 1'b1; pc_target = 32'h0000_0103;
    tick;
    chk("br_wb", pc, 32'h0000_0100);
    state_reg = S_EXEC; pc_target = 32'h0000_0207;
    tick;
    chk("br_exec", pc, 32'h0000_0100);

    // Wrap, with the sticky error still set
    state_reg = S_WB; pc_target = 32'hFFFF_FFFF;
    tick;
    pc_load = 1'b0;
    chk("wrap_load", pc, 32'hFFFF_FFFC);
    state_reg = S_FETCH;
    tick;
    chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0073; state_reg = S_DECODE;
    tick;
    mem_ready = 1'b0;
    chk("wrap_pc", pc, 32'd0);
    chk("wrap_ir", ir, 32'h0000_0073);
    chk("wrap_err_sticky", {31'd0, fetch_err}, 32'd1);
    tick;

    // Reset in the middle of a wait
    state_reg = S_WB; pc_load = 1'b1; pc_target = 32'h0000_0200;
    tick;
    pc_load = 1'b0; state_reg = S_FETCH;
    tick;
    chk("mid_req_before", {31'd0, mem_req}, 32'd1);
    state_reg = S_DECODE;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_req_drop", {31'd0, mem_req}, 32'd0);
    chk("mid_pc", pc, 32'd0);
    chk("mid_ir", ir, 32'd0);
    chk("mid_err", {31'd0, fetch_err}, 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_idle", {31'd0, mem_req}, 32'd0);
    state_reg = S_FETCH;
    tick;
    chk("post_rst_req", {31'd0, mem_req}, 32'd1);
    chk("post_rst_addr", mem_addr, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 The block SHALL provide parameter TIMEOUT, default 15, the maximum number of cycles to wait for mem_ready.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed below in the order given.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous reset, active-low: 0 resets the block, 1 runs it.
REQ-006 state_reg  input  4  control-unit state: IDLE=0000, FETCH=0001, DECODE=0010, EXECUTE=0011, WRITE_BACK=0100.
REQ-007 mem_ready  input  1  instruction memory has valid data on mem_rdata this cycle.
REQ-008 mem_rdata  input  32  instruction word from memory.
REQ-009 pc_load  input  1  request to load pc_target into the PC.
REQ-010 pc_target  input  32  branch/jump target address.
REQ-011 mem_req  output  1  registered read request to instruction memory.
REQ-012 mem_addr  output  32  read address; equals pc whenever mem_req=1.
REQ-013 ir  output  32  instruction register.
REQ-014 opcode  output  7  ir[6:0], fed to the control unit.
REQ-015 pc  output  32  program counter.
REQ-016 fetch_done  output  1  single-cycle pulse; ir updated on this cycle's edge.
REQ-017 fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-018 The internal FSM SHALL have exactly 3 states: F_IDLE, F_WAIT and F_DONE.
REQ-019 In F_IDLE with state_reg==FETCH, the next edge SHALL move to F_WAIT, set mem_req=1 and clear the wait counter.
REQ-020 In F_WAIT, mem_req SHALL stay 1 and mem_addr SHALL stay at pc until mem_ready=1 or timeout.
REQ-021 On F_WAIT with mem_ready=1, the next edge SHALL do all of: ir<=mem_rdata; pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); mem_req<=0; fetch_done<=1 for one cycle; move to F_DONE.
REQ-022 On F_WAIT with mem_ready=0, the 4-bit wait counter SHALL increment.
REQ-023 When the counter equals TIMEOUT-1 and mem_ready=0, the next edge SHALL do all of: fetch_err<=1; mem_req<=0; ir and pc unchanged; move to F_DONE.
REQ-024 mem_ready=1 on the timeout cycle SHALL win: normal capture, no error.
REQ-025 mem_ready while mem_req=0 SHALL be ignored.
REQ-026 F_DONE SHALL return to F_IDLE on the first edge with state_reg!=FETCH, giving exactly one fetch per FETCH visit.
REQ-027 If state_reg leaves FETCH during F_WAIT, the transaction SHALL still complete per REQ-021 or REQ-023; F_DONE then exits on the next edge.
REQ-028 pc_load=1 with state_reg==WRITE_BACK SHALL load pc <= {pc_target[31:2],2'b00} on the next edge.
REQ-029 pc_load in any other state SHALL be ignored.
REQ-030 pc_load SHALL never coincide with a capture, because the two occur in different states; if it does, the capture increment SHALL take priority.
REQ-031 opcode SHALL be combinational from ir with no extra latency.
REQ-032 fetch_err SHALL clear only on reset; later fetches SHALL proceed normally while it is set.
REQ-033 State values other than 0000-0100 SHALL be treated like non-FETCH states.

Reset
REQ-034 reset=0 SHALL immediately, without waiting for clk, set: FSM=F_IDLE; pc=RESET_PC; ir=0; mem_req=0; fetch_done=0; fetch_err=0; counter=0.
REQ-035 Reset asserted mid-F_WAIT SHALL abort the request with no ir/pc update; the first edge after release SHALL sample state_reg from F_IDLE.

Verification
REQ-036 Basic fetch: reset, state_reg=FETCH, mem_ready=1 two cycles later, mem_rdata=32'h0050_0093 -> mem_req high exactly 2 cycles, mem_addr=0, ir=32'h0050_0093, opcode=7'h13, pc=4, one fetch_done pulse.
REQ-037 Held FETCH: state_reg held at FETCH for 6 cycles with mem_ready pulsed once -> exactly one fetch_done, pc advances by 4 only once.
REQ-038 Timeout: mem_ready held 0 with TIMEOUT=15 -> fetch_err=1 after 15 F_WAIT cycles, mem_req=0, pc and ir unchanged; ready on cycle 15 instead -> capture, fetch_err=0.
REQ-039 Branch: pc_load=1, pc_target=32'h0000_0103 in WRITE_BACK -> pc=32'h0000_0100; same stimulus in EXECUTE -> pc unchanged.
REQ-040 Wrap and reset: pc=32'hFFFF_FFFC, fetch -> pc=0; reset=0 asserted mid-F_WAIT -> mem_req drops immediately, pc=RESET_PC, ir=0.
